// File: rtl/gpio_input_reader_if.sv
// Memory-bus attachment for the GPIO input reader.
// The CPU side drives the request; the peripheral returns ready and read data.
interface gpio_input_reader_if;
    logic        sel;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output sel,
        output mem_valid,
        output mem_addr,
        output mem_wstrb,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  sel,
        input  mem_valid,
        input  mem_addr,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/gpio_input_reader.sv
// GPIO input reader: synchronises and debounces WIDTH asynchronous pins,
// latches rising/falling edges in write-1-to-clear registers and raises a
// maskable level interrupt. Registers sit on the SoC valid/ready bus.
module gpio_input_reader #(
    parameter int WIDTH          = 8,
    parameter int PRESCALE       = 1000,
    parameter int DEBOUNCE_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [WIDTH-1:0]     pins_in,
    gpio_input_reader_if.slave   bus,
    output logic                 irq
);
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam int PRE_W = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    // Expand per-byte write strobes into a 32-bit bit mask.
    function automatic logic [31:0] strobe_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] db_cnt [WIDTH];
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] rise_clr;
    logic [WIDTH-1:0] fall_clr;
    logic [WIDTH-1:0] en_wmask;
    logic             req;
    logic             wr;
    logic [1:0]       reg_sel;
    logic [31:0]      byte_mask;
    logic [31:0]      wdata_m;
    logic [31:0]      rd_word;
    logic             unused_bits;

    assign req       = bus.mem_valid & bus.sel & ~bus.mem_ready;
    assign wr        = req & (|bus.mem_wstrb);
    assign reg_sel   = bus.mem_addr[3:2];
    assign byte_mask = strobe_mask(bus.mem_wstrb);
    assign wdata_m   = bus.mem_wdata & byte_mask;
    assign tick      = (pre_cnt == PRE_LAST);

    // Address bits [1:0] and data bits outside the register fields are ignored.
    assign unused_bits = ^{bus.mem_addr[1:0], wdata_m, byte_mask};

    // Two-flop synchroniser per pin; sync_p1 is the metastability-safe level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= pins_in;
            sync_p1 <= sync_p0;
        end
    end

    // Free-running prescaler that produces one debounce sample tick per wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    // A pin is accepted on the tick that completes DEBOUNCE_TICKS differing samples.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = tick && (sync_p1[i] != state[i]) && (db_cnt[i] == CNT_LAST);
        end
    end

    // Per-pin debounce counters and the accepted (debounced) state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((sync_p1[i] == state[i]) || accept[i]) begin
                    db_cnt[i] <= '0;
                end else if (tick) begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
            state <= (state & ~accept) | (sync_p1 & accept);
        end
    end

    // Decode bus writes into W1C clear masks and the IRQ_EN byte-write mask.
    always_comb begin
        rise_clr = '0;
        fall_clr = '0;
        en_wmask = '0;
        if (wr && (reg_sel == 2'd1)) begin
            rise_clr = wdata_m[WIDTH-1:0];
            fall_clr = wdata_m[WIDTH+15:16];
        end
        if (wr && (reg_sel == 2'd2)) begin
            en_wmask = byte_mask[WIDTH-1:0];
        end
    end

    // Edge latches (a new edge beats a same-cycle clear), enable register and irq.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rise   <= '0;
            fall   <= '0;
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            rise   <= (rise & ~rise_clr) | (accept & sync_p1);
            fall   <= (fall & ~fall_clr) | (accept & ~sync_p1);
            irq_en <= (irq_en & ~en_wmask) | (wdata_m[WIDTH-1:0] & en_wmask);
            irq    <= |((rise | fall) & irq_en);
        end
    end

    // Register read mux; sampled before any same-access W1C clear takes effect.
    always_comb begin
        rd_word = '0;
        case (reg_sel)
            2'd0: rd_word[WIDTH-1:0] = state;
            2'd1: begin
                rd_word[WIDTH-1:0]   = rise;
                rd_word[WIDTH+15:16] = fall;
            end
            2'd2: rd_word[WIDTH-1:0] = irq_en;
            default: rd_word = '0;
        endcase
    end

    // One-cycle ready pulse per accepted request; rdata is zero outside it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            bus.mem_ready <= req;
            bus.mem_rdata <= req ? rd_word : '0;
        end
    end
endmodule

// File: tb/tb_gpio_input_reader.sv
// Testbench for gpio_input_reader: directed scenarios plus random pin/bus
// traffic, checked by a scoreboard against a time-based reference model.
module tb_gpio_input_reader;
    localparam int WIDTH          = 8;
    localparam int PRESCALE       = 4;
    localparam int DEBOUNCE_TICKS = 3;
    // A differing level is accepted on the first tick after it has been seen
    // on at least this many consecutive clock edges.
    localparam int RUN_MIN = (DEBOUNCE_TICKS - 1) * PRESCALE + 1;

    logic             clk     = 1'b0;
    logic             resetn  = 1'b0;
    logic [WIDTH-1:0] pins_in = '0;
    logic             irq;

    gpio_input_reader_if bus();

    gpio_input_reader #(
        .WIDTH(WIDTH),
        .PRESCALE(PRESCALE),
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .pins_in(pins_in),
        .bus(bus),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int ready_cnt = 0;
    logic [31:0] exp_q[$];
    logic        last_rdy;

    // Reference model state
    logic [7:0] m_h0, m_h1;
    logic [7:0] m_state, m_rise, m_fall, m_en;
    logic       m_irq, m_ready;
    int         ecnt;
    int         run[8];

    task automatic model_reset();
        m_h0 = '0; m_h1 = '0; m_state = '0; m_rise = '0; m_fall = '0; m_en = '0;
        m_irq = 1'b0; m_ready = 1'b0; ecnt = 0;
        for (int i = 0; i < 8; i++) run[i] = 0;
    endtask

    task automatic model_step();
        logic [7:0] sync, acc, rclr, fclr, en_new;
        logic       tk, take;
        sync = m_h1;
        tk   = (ecnt % PRESCALE) == (PRESCALE - 1);
        acc  = '0;
        for (int i = 0; i < 8; i++) begin
            if (sync[i] != m_state[i]) begin
                run[i]++;
                if (tk && run[i] >= RUN_MIN) begin
                    acc[i] = 1'b1;
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        take   = bus.mem_valid && bus.sel && !m_ready;
        rclr   = '0;
        fclr   = '0;
        en_new = m_en;
        if (take && bus.mem_wstrb != 4'b0000) begin
            if (bus.mem_addr[3:2] == 2'd1) begin
                if (bus.mem_wstrb[0]) rclr = bus.mem_wdata[7:0];
                if (bus.mem_wstrb[2]) fclr = bus.mem_wdata[23:16];
            end else if (bus.mem_addr[3:2] == 2'd2) begin
                if (bus.mem_wstrb[0]) en_new = bus.mem_wdata[7:0];
            end
        end
        m_irq   = |((m_rise | m_fall) & m_en);
        m_rise  = (m_rise & ~rclr) | (acc & sync);
        m_fall  = (m_fall & ~fclr) | (acc & ~sync);
        m_en    = en_new;
        m_state = (m_state & ~acc) | (acc & sync);
        m_ready = take;
        m_h1    = m_h0;
        m_h0    = pins_in;
        ecnt++;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        case (addr[3:2])
            2'd0:    return {24'd0, m_state};
            2'd1:    return {8'd0, m_fall, 8'd0, m_rise};
            2'd2:    return {24'd0, m_en};
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!resetn) model_reset();
            else model_step();
        end
    end

    // Monitor: compare every cycle's ready/rdata/irq against the model.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                checks++;
                if (bus.mem_ready !== m_ready) begin
                    errors++;
                    $display("FAIL ready at %0t: got %b expected %b", $time, bus.mem_ready, m_ready);
                end
                if (bus.mem_ready === 1'b1) begin
                    ready_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rdata at %0t: ready with no pending request, got %h", $time, bus.mem_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.mem_rdata !== e) begin
                            errors++;
                            $display("FAIL rdata at %0t: got %h expected %h", $time, bus.mem_rdata, e);
                        end
                    end
                end else begin
                    checks++;
                    if (bus.mem_rdata !== 32'd0) begin
                        errors++;
                        $display("FAIL idle_rdata at %0t: got %h expected 0", $time, bus.mem_rdata);
                    end
                end
                checks++;
                if (irq !== m_irq) begin
                    errors++;
                    $display("FAIL irq at %0t: got %b expected %b", $time, irq, m_irq);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus access: request for one cycle, sample the ready cycle, then idle one.
    task automatic bus_access(input logic [3:0] addr, input logic [3:0] strb,
                              input logic [31:0] wd, output logic [31:0] rd);
        bus.sel       = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wstrb = strb;
        bus.mem_wdata = wd;
        exp_q.push_back(model_read(addr));
        @(negedge clk);
        rd       = bus.mem_rdata;
        last_rdy = bus.mem_ready;
        bus.sel       = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        int          target, guard, cnt0;

        bus.sel = 1'b0; bus.mem_valid = 1'b0; bus.mem_addr = '0;
        bus.mem_wstrb = '0; bus.mem_wdata = '0;
        last_rdy = 1'b0;

        // Reset with all pins high
        pins_in = 8'hFF;
        idle(4);
        resetn = 1'b1;
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_ready", {31'd0, bus.mem_ready}, 32'd0);
        bus_access(4'h0, 4'h0, 32'd0, rd);
        check("reset_first_state", rd, 32'd0);
        idle(20);
        bus_access(4'h0, 4'h0, 32'd0, rd);
        check("reset_state_ff", rd, 32'h0000_00FF);
        bus_access(4'h4, 4'h0, 32'd0, rd);
        check("reset_rise_ff", rd, 32'h0000_00FF);

        pins_in = 8'h00;
        idle(25);
        bus_access(4'h4, 4'hF, 32'hFFFF_FFFF, rd);
        bus_access(4'h4, 4'h0, 32'd0, rd);
        check("edge_cleared", rd, 32'd0);

        // Glitch of two ticks is rejected
        pins_in = 8'h01;
        idle(8);
        pins_in = 8'h00;
        idle(20);
        bus_access(4'h0, 4'h0, 32'd0, rd);
        check("reject_state", rd, 32'd0);
        bus_access(4'h4, 4'h0, 32'd0, rd);
        check("reject_edge", rd, 32'd0);
        check("reject_irq", {31'd0, irq}, 32'd0);

        // Long pulse on pin 3 is accepted, both edges latched
        pins_in = 8'h08;
        idle(20);
        bus_access(4'h0, 4'h0, 32'd0, rd);
        check("accept_state", rd, 32'h0000_0008);
        bus_access(4'h4, 4'h0, 32'd0, rd);
        check("accept_rise", rd, 32'h0000_0008);
        pins_in = 8'h00;
        idle(20);
        bus_access(4'h4, 4'h0, 32'd0, rd);
        check("accept_both", rd, 32'h0008_0008);

        // Interrupt enable and W1C
        bus_access(4'h8, 4'hF, 32'h0000_0008, rd);
        check("irq_after_en", {31'd0, irq}, 32'd1);
        bus_access(4'h4, 4'hF, 32'h0000_0008, rd);
        bus_access(4'h4, 4'h0, 32'd0, rd);
        check("w1c_rise", rd, 32'h0008_0000);
        check("irq_still_set", {31'd0, irq}, 32'd1);
        bus_access(4'h4, 4'hF, 32'h0008_0000, rd);
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // Zero strobes behave as a read
        bus_access(4'h8, 4'h0, 32'h0000_00FF, rd);
        check("nostrb_rdata", rd, 32'h0000_0008);
        bus_access(4'h8, 4'h0, 32'd0, rd);
        check("nostrb_en_kept", rd, 32'h0000_0008);

        // Clear of RISE[5] on the very edge the debounced pin 5 rises
        pins_in = 8'h20;
        target = ecnt + RUN_MIN + 1;
        while ((target % PRESCALE) != (PRESCALE - 1)) target++;
        guard = 0;
        while (ecnt != target && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("collision_aligned", ecnt, target);
        bus_access(4'h4, 4'hF, 32'h0000_0020, rd);
        bus_access(4'h4, 4'h0, 32'd0, rd);
        check("collision_set_wins", rd, 32'h0000_0020);
        bus_access(4'h0, 4'h0, 32'd0, rd);
        check("collision_state", rd, 32'h0000_0020);
        pins_in = 8'h00;
        idle(20);
        bus_access(4'h4, 4'hF, 32'hFFFF_FFFF, rd);

        // Reserved offset, held request, valid without select
        bus_access(4'hC, 4'hF, 32'hFFFF_FFFF, rd);
        bus_access(4'hC, 4'h0, 32'd0, rd);
        check("reserved_rdata", rd, 32'd0);
        check("reserved_ready", {31'd0, last_rdy}, 32'd1);

        bus.sel = 1'b1; bus.mem_valid = 1'b1; bus.mem_addr = 4'hC; bus.mem_wstrb = 4'h0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        cnt0 = ready_cnt;
        idle(4);
        bus.sel = 1'b0; bus.mem_valid = 1'b0;
        check("held_ready_pulses", ready_cnt - cnt0, 32'd2);
        idle(1);

        bus.sel = 1'b0; bus.mem_valid = 1'b1; bus.mem_addr = 4'h0;
        idle(1);
        check("nosel_ready_a", {31'd0, bus.mem_ready}, 32'd0);
        idle(1);
        check("nosel_ready_b", {31'd0, bus.mem_ready}, 32'd0);
        bus.mem_valid = 1'b0;
        idle(1);

        // Random pin activity and bus traffic
        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 7) == 0) pins_in = 8'($urandom);
            case ($urandom_range(0, 3))
                0: idle(1);
                1: bus_access(4'($urandom_range(0, 15)), 4'h0, $urandom, rd);
                2: bus_access(4'h4, 4'($urandom_range(0, 15)), $urandom, rd);
                default: bus_access(4'h8, 4'($urandom_range(0, 15)), $urandom, rd);
            endcase
        end

        idle(3);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
